// File: rtl/single_port_ram_byte_lane.sv
// ============================================================================
// single_port_ram_byte_lane : byte-lane single-port RAM with post-reset clear
// Rev 1.0
// ============================================================================
`default_nettype none

module single_port_ram_byte_lane #(
    parameter int ADDR_WIDTH     = 14,
    parameter int NUM_BYTES      = 4,
    parameter int READ_MODE      = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [8*NUM_BYTES-1:0]   din,
    input  logic [NUM_BYTES-1:0]     byte_en,
    input  logic                     write_en,
    input  logic                     read_en,
    output logic [8*NUM_BYTES-1:0]   dout,
    output logic                     init_done
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                   state;
    logic [ADDR_WIDTH-1:0]    clr_cnt;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic                     out_mask;
    logic                     ready;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [8*NUM_BYTES-1:0]   wr_data;
    logic [NUM_BYTES-1:0]     wr_lane;
    logic [8*NUM_BYTES-1:0]   rd_word;
    logic [8*NUM_BYTES-1:0]   stage1;

    // The clear engine owns the write port until READY; the read address holds.
    always_comb begin
        ready   = (state == READY);
        rd_addr = (ready && read_en) ? addr : addr_q;
        wr_addr = ready ? addr : clr_cnt;
        wr_data = ready ? din : '0;
        wr_lane = ready ? (write_en ? byte_en : '0) : '1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt   <= '0;
            init_done <= (CLEAR_ON_RESET == 0);
            addr_q    <= '0;
            out_mask  <= 1'b1;
        end else begin
            addr_q   <= rd_addr;
            out_mask <= !ready;
            if (!ready) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state     <= READY;
                    init_done <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
        logic [7:0] mem [0:DEPTH-1];
        logic [7:0] lane_q;

        always_ff @(posedge clk) begin
            if (wr_lane[k]) begin
                mem[wr_addr] <= wr_data[8*k +: 8];
            end
        end

        if (READ_MODE == 1) begin : g_write_through
            always_ff @(posedge clk) begin
                lane_q <= (wr_lane[k] && (wr_addr == rd_addr)) ? wr_data[8*k +: 8]
                                                                : mem[rd_addr];
            end
        end else begin : g_read_first
            always_ff @(posedge clk) begin
                lane_q <= mem[rd_addr];
            end
        end

        assign rd_word[8*k +: 8] = lane_q;
    end

    // RAM output register is not reset; a reset-driven mask forces zero instead.
    assign stage1 = out_mask ? '0 : rd_word;

    if (OUT_REG != 0) begin : g_out_reg
        logic [8*NUM_BYTES-1:0] stage2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage2 <= '0;
            end else begin
                stage2 <= stage1;
            end
        end

        assign dout = stage2;
    end else begin : g_no_out_reg
        assign dout = stage1;
    end

endmodule

`default_nettype wire

// File: tb/tb_single_port_ram_byte_lane.sv
// ============================================================================
// tb_single_port_ram_byte_lane : scoreboard bench for the byte-lane RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_single_port_ram_byte_lane;

    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int RM    = 0;
    localparam int ORG   = 0;
    localparam int CLR   = 1;
    localparam int LAT   = (ORG != 0) ? 2 : 1;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [8*NB-1:0] din = '0;
    logic [NB-1:0]   byte_en = '0;
    logic            write_en = 1'b0;
    logic            read_en = 1'b0;
    logic [8*NB-1:0] dout;
    logic            init_done;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n;

    single_port_ram_byte_lane #(
        .ADDR_WIDTH     (AW),
        .NUM_BYTES      (NB),
        .READ_MODE      (RM),
        .OUT_REG        (ORG),
        .CLEAR_ON_RESET (CLR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .din       (din),
        .byte_en   (byte_en),
        .write_en  (write_en),
        .read_en   (read_en),
        .dout      (dout),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en = 1'b0;
        read_en  = 1'b0;
        byte_en  = '0;
    endtask

    task automatic push_read(input logic [AW-1:0] a, input logic [31:0] ex);
        addr     = a;
        read_en  = 1'b1;
        write_en = 1'b0;
        exp_q.push_back(ex);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [NB-1:0] be);
        addr     = a;
        din      = d;
        byte_en  = be;
        write_en = 1'b1;
        read_en  = 1'b0;
        cycle();
        idle();
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 100) begin
            cycle();
            cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) cycle();
        checks++;
        if (dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h expected %h", dout, 32'h0);
        end
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_done: got %b expected 0", init_done);
        end
    endtask

    task automatic test_clear();
        reset_n = 1'b1;
        wait_init(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_cycles: got %0d expected %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) do_write(i[AW-1:0], 32'hA5A5A5A5, 4'hF);
        push_read(4'd7, 32'hA5A5A5A5);
        cycle();
        idle();
        repeat (LAT - 1) cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL preload_read: got %h expected %h", dout, e);
        end
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        wait_init(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reclear_cycles: got %0d expected %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH + LAT - 1; i++) begin
            if (i < DEPTH) push_read(i[AW-1:0], 32'h0);
            else           idle();
            cycle();
            if (i >= LAT - 1) begin
                e = exp_q.pop_front();
                checks++;
                if (dout !== e) begin
                    errors++;
                    $display("FAIL clear_read[%0d]: got %h expected %h", i - LAT + 1, dout, e);
                end
            end
        end
        idle();
    endtask

    task automatic test_byte_lane();
        do_write(4'd3, 32'h11223344, 4'b1111);
        do_write(4'd3, 32'hAABBCCDD, 4'b0101);
        push_read(4'd3, 32'h11BB33DD);
        cycle();
        idle();
        repeat (LAT - 1) cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL byte_lane: got %h expected %h", dout, e);
        end
    endtask

    task automatic test_rdw();
        do_write(4'd5, 32'h00000001, 4'hF);
        addr     = 4'd5;
        din      = 32'hFFFFFFFF;
        byte_en  = 4'b0011;
        write_en = 1'b1;
        read_en  = 1'b1;
        exp_q.push_back((RM == 1) ? 32'h0000FFFF : 32'h00000001);
        cycle();
        idle();
        repeat (LAT - 1) cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL rdw_same_cycle: got %h expected %h", dout, e);
        end
        push_read(4'd5, 32'h0000FFFF);
        cycle();
        idle();
        repeat (LAT - 1) cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL rdw_next_read: got %h expected %h", dout, e);
        end
    endtask

    task automatic test_latency();
        // dout currently shows addr 5 = 0000FFFF
        push_read(4'd3, 32'h11BB33DD);
        cycle();
        idle();
        e = (LAT == 1) ? exp_q[0] : 32'h0000FFFF;
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL latency_n1: got %h expected %h", dout, e);
        end
        cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL latency_n2: got %h expected %h", dout, e);
        end
    endtask

    task automatic test_reset_mid_clear();
        reset_n = 1'b0;
        #2;
        checks++;
        if (dout !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_dout: got %h expected %h", dout, 32'h0);
        end
        cycle();
        reset_n = 1'b1;
        addr    = 4'd3;
        read_en = 1'b1;
        repeat (7) cycle();
        checks++;
        if (dout !== 32'h0) begin
            errors++;
            $display("FAIL clear_dout_held: got %h expected %h", dout, 32'h0);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL midclear_init_done: got %b expected 0", init_done);
        end
        idle();
        cycle();
        reset_n = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            if (n == 10) begin
                addr     = 4'd2;
                din      = 32'hDEADBEEF;
                byte_en  = 4'hF;
                write_en = 1'b1;
            end else begin
                write_en = 1'b0;
            end
            cycle();
            n++;
        end
        idle();
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL midclear_cycles: got %0d expected %0d", n, DEPTH);
        end
        push_read(4'd2, 32'h0);
        cycle();
        idle();
        repeat (LAT - 1) cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL write_during_clear: got %h expected %h", dout, e);
        end
    endtask

    task automatic test_be_zero_hold();
        do_write(4'd3, 32'h11223344, 4'hF);
        do_write(4'd3, 32'hFFFFFFFF, 4'h0);
        push_read(4'd3, 32'h11223344);
        cycle();
        idle();
        repeat (LAT - 1) cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL be_zero: got %h expected %h", dout, e);
        end
        exp_q.push_back(32'h99223344);
        do_write(4'd3, 32'h99000000, 4'b1000);
        addr = 4'd9;
        repeat (LAT) cycle();
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL read_en_hold: got %h expected %h", dout, e);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_lane();
        test_rdw();
        test_latency();
        test_reset_mid_clear();
        test_be_zero_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
